// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: frame controller around a Viterbi ACS core and traceback unit.
// Buffers up to MAX_LEN two-bit symbols, streams them to the ACS core, starts the
// traceback, collects the decoded bits and hands them to the host one at a time.
// Optional build macro VITERBI_CTRL_AUTOSTART_EN: a frame that fills the buffer
// starts decoding on its own, without waiting for a start pulse.
module viterbi_frame_ctrl #(
    parameter int MAX_LEN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sym_valid,
    input  logic [1:0] sym_data,
    output logic       rx_ready,
    input  logic       start,
    input  logic       out_ack,
    output logic       out_valid,
    output logic       out_bit,
    output logic       busy,
    output logic       frame_done,
    output logic       acs_valid,
    output logic [1:0] acs_sym,
    input  logic       acs_ready,
    output logic       tb_start,
    output logic [5:0] tb_len,
    input  logic       tb_bit_we,
    input  logic [4:0] tb_bit_idx,
    input  logic       tb_bit,
    input  logic       tb_done
);

    localparam int         IDX_W     = $clog2(MAX_LEN);
    localparam logic [5:0] MAX_LEN_W = 6'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACS,
        S_TRACE,
        S_OUT,
        S_DONE
    } state_t;

    state_t             state_q, state_n;
    logic [5:0]         len_q, len_n, len_base;
    logic [5:0]         rd_idx_q, rd_idx_n;
    logic [MAX_LEN-1:0] dec_q;
    logic [1:0]         sym_mem [MAX_LEN];

    logic rx_ready_q, out_valid_q, busy_q, frame_done_q, acs_valid_q, tb_start_q;
    logic [5:0] tb_len_q;
    logic rx_ready_n, tb_start_n;
    logic accept, acs_fire, out_fire;

    assign accept   = sym_valid && rx_ready_q;
    assign acs_fire = acs_valid_q && acs_ready;
    assign out_fire = out_valid_q && out_ack;
    // A symbol arriving in DONE opens a new frame, so it lands at index 0.
    assign len_base = (state_q == S_DONE) ? 6'd0 : len_q;

    // Next-state, frame length, read pointer and traceback-request decode.
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_n    = state_q;
        len_n      = len_q;
        rd_idx_n   = rd_idx_q;
        tb_start_n = 1'b0;
        unique case (state_q)
            S_IDLE, S_LOAD, S_DONE: begin
                if (accept) begin
                    len_n   = len_base + 6'd1;
                    state_n = S_LOAD;
                end
                // The symbol is taken before start is looked at; LOAD or a fresh
                // accept both guarantee at least one buffered symbol.
                if (start && (state_q == S_LOAD || accept)) begin
                    state_n  = S_ACS;
                    rd_idx_n = '0;
                end
`ifdef VITERBI_CTRL_AUTOSTART_EN
                if (accept && len_n == MAX_LEN_W) begin
                    state_n  = S_ACS;
                    rd_idx_n = '0;
                end
`endif
            end
            S_ACS: begin
                if (acs_fire) begin
                    rd_idx_n = rd_idx_q + 6'd1;
                    if (rd_idx_q + 6'd1 == len_q) begin
                        state_n    = S_TRACE;
                        tb_start_n = 1'b1;
                    end
                end
            end
            S_TRACE: begin
                if (tb_done) begin
                    state_n  = S_OUT;
                    rd_idx_n = '0;
                end
            end
            S_OUT: begin
                if (out_fire) begin
                    rd_idx_n = rd_idx_q + 6'd1;
                    if (rd_idx_q + 6'd1 == len_q) state_n = S_DONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        rx_ready_n = (state_n == S_IDLE || state_n == S_LOAD || state_n == S_DONE)
                     && (len_n < MAX_LEN_W);
    end

    // Control state and registered outputs, all derived from the next state.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            rd_idx_q     <= '0;
            rx_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            acs_valid_q  <= 1'b0;
            tb_start_q   <= 1'b0;
            tb_len_q     <= '0;
        end else begin
            state_q      <= state_n;
            len_q        <= len_n;
            rd_idx_q     <= rd_idx_n;
            rx_ready_q   <= rx_ready_n;
            out_valid_q  <= (state_n == S_OUT);
            busy_q       <= (state_n == S_ACS) || (state_n == S_TRACE);
            frame_done_q <= (state_n == S_DONE);
            acs_valid_q  <= (state_n == S_ACS);
            tb_start_q   <= tb_start_n;
            tb_len_q     <= len_n;
        end
    end

    // Decoded-bit store written by the traceback unit; indices past the frame are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= '0;
        end else if (state_q == S_TRACE && tb_bit_we && ({1'b0, tb_bit_idx} < len_q)) begin
            dec_q[tb_bit_idx[IDX_W-1:0]] <= tb_bit;
        end
    end

    // Symbol buffer write on every accepted symbol.
    // NOTE: the buffer has no reset; it is only read at indices written in the current frame.
    always_ff @(posedge clk) begin
        if (accept) sym_mem[len_base[IDX_W-1:0]] <= sym_data;
    end

    assign rx_ready   = rx_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign acs_valid  = acs_valid_q;
    assign tb_start   = tb_start_q;
    assign tb_len     = tb_len_q;
    // Buffer reads are gated so both read ports sit at 0 when not offering data.
    assign acs_sym    = acs_valid_q ? sym_mem[rd_idx_q[IDX_W-1:0]] : 2'b00;
    assign out_bit    = out_valid_q ? dec_q[rd_idx_q[IDX_W-1:0]] : 1'b0;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb_viterbi_frame_ctrl: randomized self-checking bench for viterbi_frame_ctrl.
// Reference model: the ACS core must see exactly the queued host symbols in order,
// the host must read back exactly the bits the traceback wrote (index order), and
// tb_len must equal the number of symbols sent. Honors VITERBI_CTRL_AUTOSTART_EN.
module tb_viterbi_frame_ctrl;

    logic       clk;
    logic       rst_n;
    logic       sym_valid;
    logic [1:0] sym_data;
    logic       rx_ready;
    logic       start;
    logic       out_ack;
    logic       out_valid;
    logic       out_bit;
    logic       busy;
    logic       frame_done;
    logic       acs_valid;
    logic [1:0] acs_sym;
    logic       acs_ready;
    logic       tb_start;
    logic [5:0] tb_len;
    logic       tb_bit_we;
    logic [4:0] tb_bit_idx;
    logic       tb_bit;
    logic       tb_done;

    viterbi_frame_ctrl #(.MAX_LEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .rx_ready   (rx_ready),
        .start      (start),
        .out_ack    (out_ack),
        .out_valid  (out_valid),
        .out_bit    (out_bit),
        .busy       (busy),
        .frame_done (frame_done),
        .acs_valid  (acs_valid),
        .acs_sym    (acs_sym),
        .acs_ready  (acs_ready),
        .tb_start   (tb_start),
        .tb_len     (tb_len),
        .tb_bit_we  (tb_bit_we),
        .tb_bit_idx (tb_bit_idx),
        .tb_bit     (tb_bit),
        .tb_done    (tb_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model and observation state.
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];
    logic       out_got[$];
    int         tb_start_cnt;
    int         tb_len_seen;
    bit         busy_drop;
    bit         acs_timeout;
    bit         out_timeout;
    int         rejected;

    function automatic int first_sym_diff();
        if (got_q.size() != exp_q.size()) return -2;
        foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic int first_bit_diff(input logic [31:0] bits, input int n);
        if (out_got.size() != n) return -2;
        for (int i = 0; i < n; i++) if (out_got[i] !== bits[i]) return i;
        return -1;
    endfunction

    task automatic clear_inputs();
        sym_valid = 0; sym_data = 0; start = 0; out_ack = 0; acs_ready = 0;
        tb_bit_we = 0; tb_bit_idx = 0; tb_bit = 0; tb_done = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    // Offer n random symbols back to back; start optionally rides on the last one.
    task automatic send_frame(input int n, input bit start_last);
        logic [1:0] d;
        for (int i = 0; i < n; i++) begin
            d = 2'($urandom_range(3));
            if (rx_ready !== 1'b1) rejected++;
            sym_valid = 1; sym_data = d; start = start_last && (i == n - 1);
            exp_q.push_back(d);
            @(negedge clk);
        end
        sym_valid = 0; sym_data = 0; start = 0;
    endtask

    // Play the ACS core. mode 0: always ready, 1: ready toggles 1-0-1-0, 2: random.
    // Host noise (sym_valid/start) is driven meanwhile and must be ignored.
    task automatic collect_acs(input int mode);
        int  after;
        bit  seen;
        got_q.delete();
        tb_start_cnt = 0; tb_len_seen = 0; busy_drop = 0; acs_timeout = 1;
        seen = 0; after = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            case (mode)
                0:       acs_ready = 1;
                1:       acs_ready = (cyc % 2 == 0);
                default: acs_ready = 1'($urandom_range(1));
            endcase
            sym_valid = 1'($urandom_range(1));
            sym_data  = 2'($urandom_range(3));
            start     = 1'($urandom_range(1));
            if (busy !== 1'b1) busy_drop = 1;
            if (tb_start === 1'b1) begin
                tb_start_cnt++;
                tb_len_seen = int'(tb_len);
                seen = 1;
            end
            if (acs_valid === 1'b1 && acs_ready) got_q.push_back(acs_sym);
            if (seen) after++;
            if (after == 3) begin
                acs_timeout = 0;
                break;
            end
            @(negedge clk);
        end
        acs_ready = 0; sym_valid = 0; sym_data = 0; start = 0;
    endtask

    // Play the traceback unit: write n bits in shuffled index order, tb_done with the last write.
    task automatic drive_trace(input logic [31:0] bits, input int n, input bit stray_ack);
        int perm[32];
        int j, t;
        for (int i = 0; i < n; i++) perm[i] = i;
        for (int i = n - 1; i > 0; i--) begin
            j = $urandom_range(i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        if (stray_ack) begin
            out_ack = 1;
            @(negedge clk);
            out_ack = 0;
        end
        for (int i = 0; i < n; i++) begin
            tb_bit_we = 1; tb_bit_idx = 5'(perm[i]); tb_bit = bits[perm[i]];
            tb_done = (i == n - 1);
            @(negedge clk);
        end
        tb_bit_we = 0; tb_done = 0; tb_bit_idx = 0; tb_bit = 0;
    endtask

    // Play the host reader with 0-3 cycle stalls before each ack.
    task automatic read_out(input int n);
        out_got.delete();
        out_timeout = 0;
        for (int k = 0; k < n; k++) begin
            int w = 0;
            repeat ($urandom_range(3)) @(negedge clk);
            while (out_valid !== 1'b1 && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (out_valid !== 1'b1) begin
                out_timeout = 1;
                break;
            end
            out_got.push_back(out_bit);
            out_ack = 1;
            @(negedge clk);
            out_ack = 0;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rx_ready, out_valid, busy, frame_done, acs_valid, tb_start} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 000000", {rx_ready, out_valid, busy, frame_done, acs_valid, tb_start});
        end
        checks++;
        if ({tb_len, acs_sym, out_bit} !== 9'b0) begin
            errors++;
            $display("FAIL reset_data: tb_len=%0d acs_sym=%0d out_bit=%0d, expected all 0", tb_len, acs_sym, out_bit);
        end
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_rx_ready: got %b, expected 1", rx_ready);
        end
    endtask

    task automatic test_basic_frame();
        logic [31:0] bits;
        int diff;
        do_reset();
        exp_q.delete(); rejected = 0;
        send_frame(8, 0);
        checks++;
        if (rejected != 0) begin errors++; $display("FAIL basic_rx: %0d symbols refused, expected 0", rejected); end
        start = 1;
        @(negedge clk);
        start = 0;
        collect_acs(0);
        diff = first_sym_diff();
        checks++;
        if (acs_timeout || diff != -1) begin
            errors++;
            $display("FAIL basic_acs: got %0d beats (diff %0d, timeout %0b), expected %0d", got_q.size(), diff, acs_timeout, exp_q.size());
        end
        checks++;
        if (tb_start_cnt != 1 || tb_len_seen != 8) begin
            errors++;
            $display("FAIL basic_tb_start: pulses=%0d tb_len=%0d, expected 1 and 8", tb_start_cnt, tb_len_seen);
        end
        checks++;
        if (busy_drop) begin errors++; $display("FAIL basic_busy: busy dropped during ACS/TRACE, expected held 1"); end
        bits = 32'h0000_00B4;
        drive_trace(bits, 8, 1);
        read_out(8);
        diff = first_bit_diff(bits, 8);
        checks++;
        if (out_timeout || diff != -1) begin
            errors++;
            $display("FAIL basic_out: got %0d bits (diff %0d, timeout %0b), expected 0,0,1,0,1,1,0,1", out_got.size(), diff, out_timeout);
        end
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: frame_done=%b busy=%b out_valid=%b, expected 1 0 0", frame_done, busy, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            int n;
            int diff;
            logic [31:0] bits;
            n = $urandom_range(12, 5);
            bits = $urandom;
            checks++;
            if (frame_done !== 1'b1 || rx_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_pre: frame_done=%b rx_ready=%b, expected 1 1", frame_done, rx_ready);
            end
            exp_q.delete(); rejected = 0;
            send_frame(n, 1);
            checks++;
            if (rejected != 0 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL b2b_load: refused=%0d frame_done=%b, expected 0 0", rejected, frame_done);
            end
            collect_acs(f == 0 ? 1 : 2);
            diff = first_sym_diff();
            checks++;
            if (acs_timeout || diff != -1 || tb_len_seen != n || tb_start_cnt != 1) begin
                errors++;
                $display("FAIL b2b_acs: beats=%0d diff=%0d tb_len=%0d pulses=%0d, expected %0d beats, tb_len %0d, 1 pulse", got_q.size(), diff, tb_len_seen, tb_start_cnt, n, n);
            end
            drive_trace(bits, n, 0);
            read_out(n);
            diff = first_bit_diff(bits, n);
            checks++;
            if (out_timeout || diff != -1 || frame_done !== 1'b1) begin
                errors++;
                $display("FAIL b2b_out: bits=%0d diff=%0d frame_done=%b, expected %0d bits and frame_done 1", out_got.size(), diff, frame_done, n);
            end
        end
    endtask

    task automatic test_start_edge();
        logic [31:0] bits;
        int diff;
        do_reset();
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || acs_valid !== 1'b0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL empty_start: busy=%b acs_valid=%b rx_ready=%b, expected 0 0 1", busy, acs_valid, rx_ready);
        end
        exp_q.delete();
        send_frame(1, 1);
        collect_acs(0);
        diff = first_sym_diff();
        checks++;
        if (acs_timeout || diff != -1 || tb_len_seen != 1 || tb_start_cnt != 1) begin
            errors++;
            $display("FAIL coincident_start: beats=%0d diff=%0d tb_len=%0d pulses=%0d, expected 1 beat, tb_len 1, 1 pulse", got_q.size(), diff, tb_len_seen, tb_start_cnt);
        end
        bits = $urandom;
        drive_trace(bits, 1, 0);
        read_out(1);
        diff = first_bit_diff(bits, 1);
        checks++;
        if (out_timeout || diff != -1 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL coincident_out: bits=%0d diff=%0d frame_done=%b, expected 1 bit = %b and frame_done 1", out_got.size(), diff, frame_done, bits[0]);
        end
    endtask

    task automatic test_full_frame();
        logic [31:0] bits;
        int diff;
        do_reset();
        exp_q.delete(); rejected = 0;
        send_frame(32, 0);
        checks++;
        if (rejected != 0) begin errors++; $display("FAIL full_rx: %0d symbols refused, expected 0", rejected); end
`ifdef VITERBI_CTRL_AUTOSTART_EN
        checks++;
        if (acs_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_autostart: acs_valid=%b busy=%b, expected 1 1", acs_valid, busy);
        end
`else
        sym_valid = 1; sym_data = 2'($urandom_range(3));
        repeat (3) @(negedge clk);
        checks++;
        if (rx_ready !== 1'b0 || acs_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_hold: rx_ready=%b acs_valid=%b busy=%b, expected 0 0 0", rx_ready, acs_valid, busy);
        end
        sym_valid = 0;
        start = 1;
        @(negedge clk);
        start = 0;
`endif
        collect_acs(2);
        diff = first_sym_diff();
        checks++;
        if (acs_timeout || diff != -1 || tb_len_seen != 32) begin
            errors++;
            $display("FAIL full_acs: beats=%0d diff=%0d tb_len=%0d, expected 32 beats and tb_len 32", got_q.size(), diff, tb_len_seen);
        end
        bits = $urandom;
        drive_trace(bits, 32, 0);
        read_out(32);
        diff = first_bit_diff(bits, 32);
        checks++;
        if (out_timeout || diff != -1 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL full_out: bits=%0d diff=%0d frame_done=%b, expected 32 bits and frame_done 1", out_got.size(), diff, frame_done);
        end
    endtask

    task automatic test_reset_mid_trace();
        logic [31:0] bits;
        int diff;
        do_reset();
        exp_q.delete();
        send_frame(16, 1);
        collect_acs(0);
        checks++;
        if (acs_timeout || tb_len_seen != 16) begin
            errors++;
            $display("FAIL midreset_setup: tb_len=%0d timeout=%0b, expected 16 0", tb_len_seen, acs_timeout);
        end
        for (int i = 0; i < 16; i++) begin
            tb_bit_we = 1; tb_bit_idx = 5'(i); tb_bit = 1;
            @(negedge clk);
        end
        tb_bit_we = 0; tb_bit = 0; tb_bit_idx = 0;
        #2 rst_n = 0;
        #1;
        checks++;
        if ({busy, out_valid, acs_valid, tb_start, frame_done, rx_ready} !== 6'b0) begin
            errors++;
            $display("FAIL midreset_async: busy,out_valid,acs_valid,tb_start,frame_done,rx_ready=%b, expected 000000", {busy, out_valid, acs_valid, tb_start, frame_done, rx_ready});
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release: rx_ready=%b busy=%b, expected 1 0", rx_ready, busy);
        end
        exp_q.delete();
        send_frame(4, 1);
        collect_acs(2);
        diff = first_sym_diff();
        checks++;
        if (acs_timeout || diff != -1 || tb_len_seen != 4) begin
            errors++;
            $display("FAIL midreset_acs: beats=%0d diff=%0d tb_len=%0d, expected 4 beats and tb_len 4", got_q.size(), diff, tb_len_seen);
        end
        // Only even indices are written; odd ones must read back as the reset value 0.
        bits = '0;
        bits[0] = 1'($urandom_range(1));
        bits[2] = 1'($urandom_range(1));
        tb_bit_we = 1; tb_bit_idx = 5'd2; tb_bit = bits[2];
        @(negedge clk);
        tb_bit_idx = 5'd0; tb_bit = bits[0];
        @(negedge clk);
        tb_bit_we = 0; tb_done = 1;
        @(negedge clk);
        tb_done = 0; tb_bit = 0; tb_bit_idx = 0;
        read_out(4);
        diff = first_bit_diff(bits, 4);
        checks++;
        if (out_timeout || diff != -1 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL midreset_out: bits=%0d diff=%0d frame_done=%b, expected %b%b%b%b (bit0 first) and frame_done 1", out_got.size(), diff, frame_done, bits[0], bits[1], bits[2], bits[3]);
        end
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_start_edge();
        test_full_frame();
        test_reset_mid_trace();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
